// File: rtl/sr_pkg.sv
// Shared search-region memory parameters and loader state type.
// Also imported by the ME read controller.
package sr_pkg;
   localparam int PIX_W       = 8;
   localparam int ROW_PIX     = 11;
   localparam int ROWS        = 19;
   localparam int ROW_W       = PIX_W * ROW_PIX;
   localparam int SR_ADDR_W   = 6;
   localparam int SR_BANK_BIT = 5;
   localparam int ROW_CNT_W   = SR_BANK_BIT;
   localparam int PIX_CNT_W   = $clog2(ROW_PIX);

   typedef enum logic {FILL, STALL} sr_state_e;
endpackage

// File: rtl/sr_row_packer.sv
// Shift-in packer: the first pixel of a row ends up in the MSBs.
// clear restarts the row; if a pixel is pushed together with clear, it becomes pixel 0.
module sr_row_packer
   import sr_pkg::*;
(
   input  logic                 clk,
   input  logic                 push,
   input  logic                 clear,
   input  logic [PIX_W-1:0]     pix,
   output logic [PIX_CNT_W-1:0] pix_cnt,
   output logic                 row_done,
   output logic [ROW_W-1:0]     row_word
);
   localparam int HELD_W = ROW_W - PIX_W;

   logic [PIX_CNT_W-1:0] cnt_q, cnt_d;
   logic [HELD_W-1:0]    held_q, held_d;
   logic                 last_pix;

   always_comb begin
      last_pix = (cnt_q == PIX_CNT_W'(ROW_PIX - 1));
      row_word = {held_q, pix};
      row_done = push && !clear && last_pix;
      cnt_d    = cnt_q;
      held_d   = held_q;
      if (clear) begin
         cnt_d  = push ? PIX_CNT_W'(1) : '0;
         held_d = push ? HELD_W'(pix) : '0;
      end else if (push) begin
         cnt_d  = last_pix ? '0 : cnt_q + PIX_CNT_W'(1);
         held_d = row_word[HELD_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      cnt_q  <= cnt_d;
      held_q <= held_d;
   end

   assign pix_cnt = cnt_q;
endmodule

// File: rtl/sr_loader.sv
// Write-side controller for the double-banked search-region memory.
//   state | meaning
//   FILL  | current write bank is free, pixels accepted
//   STALL | current write bank still owned by the ME engine, pix_ready low
module sr_loader
   import sr_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 pix_valid,
   input  logic                 pix_sof,
   input  logic [PIX_W-1:0]     pix_data,
   output logic                 pix_ready,
   output logic                 memWrite,
   output logic [SR_ADDR_W-1:0] sr_addressWrite,
   output logic [ROW_W-1:0]     writeData,
   output logic [1:0]           bank_full,
   input  logic [1:0]           bank_release,
   output logic                 err_resync
);
   sr_state_e            state_q, state_d;
   logic                 wr_bank_q, wr_bank_d;
   logic [ROW_CNT_W-1:0] row_cnt_q, row_cnt_d;
   logic [1:0]           bank_full_q, bank_full_d;
   logic [1:0]           set_pend_q, set_pend_d;
   logic                 mem_write_q, mem_write_d;
   logic [SR_ADDR_W-1:0] addr_q, addr_d;
   logic [ROW_W-1:0]     data_q, data_d;
   logic                 err_q, err_d;

   logic                 accept, sof_acc, resync, row_done;
   logic [PIX_CNT_W-1:0] pix_cnt;
   logic [ROW_W-1:0]     row_word;

   assign pix_ready = !rst && (state_q == FILL);

   sr_row_packer u_packer (
      .clk      (clk),
      .push     (accept),
      .clear    (rst | sof_acc),
      .pix      (pix_data),
      .pix_cnt  (pix_cnt),
      .row_done (row_done),
      .row_word (row_word)
   );

   always_comb begin
      accept      = pix_valid && pix_ready;
      sof_acc     = accept && pix_sof;
      resync      = sof_acc && ((pix_cnt != '0) || (row_cnt_q != '0));
      mem_write_d = 1'b0;
      addr_d      = addr_q;
      data_d      = data_q;
      row_cnt_d   = row_cnt_q;
      wr_bank_d   = wr_bank_q;
      set_pend_d  = 2'b00;
      err_d       = resync;
      if (sof_acc) begin
         row_cnt_d = '0;
      end else if (row_done) begin
         mem_write_d = 1'b1;
         addr_d      = {wr_bank_q, row_cnt_q};
         data_d      = row_word;
         if (row_cnt_q == ROW_CNT_W'(ROWS - 1)) begin
            row_cnt_d             = '0;
            wr_bank_d             = !wr_bank_q;
            set_pend_d[wr_bank_q] = 1'b1;
         end else begin
            row_cnt_d = row_cnt_q + ROW_CNT_W'(1);
         end
      end
      // a bank is only marked full once its last row write has been issued
      bank_full_d = (bank_full_q & ~bank_release) | set_pend_q;
      state_d     = bank_full_d[wr_bank_d] ? STALL : FILL;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= FILL;
         wr_bank_q   <= 1'b0;
         row_cnt_q   <= '0;
         bank_full_q <= 2'b00;
         set_pend_q  <= 2'b00;
         mem_write_q <= 1'b0;
         addr_q      <= '0;
         data_q      <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_bank_q   <= wr_bank_d;
         row_cnt_q   <= row_cnt_d;
         bank_full_q <= bank_full_d;
         set_pend_q  <= set_pend_d;
         mem_write_q <= mem_write_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         err_q       <= err_d;
      end
   end

   assign memWrite        = mem_write_q;
   assign sr_addressWrite = addr_q;
   assign writeData       = data_q;
   assign bank_full       = bank_full_q;
   assign err_resync      = err_q;
endmodule

// File: tb/tb_sr_loader.sv
// Bench for sr_loader: a queue-based reference model is checked against the DUT every cycle,
// followed by directed scenarios and a randomized multi-region run.
module tb_sr_loader;
   localparam int NPIX  = 11;
   localparam int NROWS = 19;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pix_valid = 1'b0;
   logic        pix_sof = 1'b0;
   logic [7:0]  pix_data = '0;
   logic        pix_ready;
   logic        memWrite;
   logic [5:0]  sr_addressWrite;
   logic [87:0] writeData;
   logic [1:0]  bank_full;
   logic [1:0]  bank_release = 2'b00;
   logic        err_resync;

   sr_loader dut (
      .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_data(pix_data),
      .pix_ready(pix_ready), .memWrite(memWrite), .sr_addressWrite(sr_addressWrite),
      .writeData(writeData), .bank_full(bank_full), .bank_release(bank_release),
      .err_resync(err_resync)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // reference model state
   logic [1:0]  m_full = 2'b00;
   logic [1:0]  m_pend = 2'b00;
   logic        m_bank = 1'b0;
   logic [4:0]  m_row = '0;
   logic [7:0]  m_q[$];
   logic        m_mw = 1'b0;
   logic [5:0]  m_addr = '0;
   logic [87:0] m_data = '0;
   logic        m_err = 1'b0;
   logic        m_hold = 1'b1;
   int          m_writes = 0;

   // observation log
   int          wr_cnt = 0;
   int          err_seen = 0;
   logic [5:0]  first_addr, last_addr;
   logic [87:0] first_data;

   task automatic chk(input string nm, input logic [87:0] act, input logic [87:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic clr_log();
      wr_cnt = 0;
      err_seen = 0;
   endtask

   task automatic tick(input logic r, input logic v, input logic s, input logic [7:0] d,
                       input logic [1:0] rel, output logic acc);
      logic exp_ready;
      logic [1:0] nf;
      rst = r; pix_valid = v; pix_sof = s; pix_data = d; bank_release = rel;
      #1;
      exp_ready = !r && !m_full[m_bank];
      chk("pix_ready", 88'(pix_ready), 88'(exp_ready));
      chk("memWrite", 88'(memWrite), 88'(m_mw));
      chk("bank_full", 88'(bank_full), 88'(m_full));
      chk("err_resync", 88'(err_resync), 88'(m_err));
      if (m_mw || m_hold) begin
         chk("sr_addressWrite", 88'(sr_addressWrite), 88'(m_addr));
         chk("writeData", writeData, m_data);
      end
      if (memWrite === 1'b1) begin
         chk("write_target_free", 88'(bank_full[sr_addressWrite[5]]), 88'(0));
         wr_cnt++;
         if (wr_cnt == 1) begin
            first_addr = sr_addressWrite;
            first_data = writeData;
         end
         last_addr = sr_addressWrite;
      end
      if (err_resync === 1'b1) err_seen++;

      acc = v && exp_ready;
      nf = (m_full & ~rel) | m_pend;
      m_pend = 2'b00; m_mw = 1'b0; m_err = 1'b0;
      if (r) begin
         m_full = 2'b00; m_bank = 1'b0; m_row = '0; m_q.delete();
         m_addr = '0; m_data = '0; m_hold = 1'b1;
      end else begin
         m_hold = 1'b0;
         m_full = nf;
         if (acc) begin
            if (s) begin
               if (m_q.size() != 0 || m_row != 0) m_err = 1'b1;
               m_q.delete();
               m_row = '0;
            end
            m_q.push_back(d);
            if (m_q.size() == NPIX) begin
               m_mw = 1'b1;
               m_writes++;
               m_addr = {m_bank, m_row};
               m_data = '0;
               foreach (m_q[i]) m_data = {m_data[79:0], m_q[i]};
               m_q.delete();
               if (int'(m_row) == NROWS - 1) begin
                  m_row = '0;
                  m_pend[m_bank] = 1'b1;
                  m_bank = !m_bank;
               end else begin
                  m_row = m_row + 5'd1;
               end
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic idle(input logic [1:0] rel);
      logic a;
      tick(1'b0, 1'b0, 1'b0, 8'h00, rel, a);
   endtask

   task automatic send(input logic [7:0] d, input logic s);
      logic a;
      int n;
      n = 0;
      a = 1'b0;
      while (!a && n < 2000) begin
         tick(1'b0, 1'b1, s, d, 2'b00, a);
         n++;
      end
      if (!a) chk("send_timeout", 88'(0), 88'(1));
   endtask

   task automatic stream(input int n, input int start);
      for (int i = 0; i < n; i++) send(8'(start + i), 1'b0);
   endtask

   initial begin
      logic a;
      int start;
      int cyc;
      logic [1:0] rel;
      logic [87:0] tmp;

      @(negedge clk);
      tick(1'b1, 1'b0, 1'b0, 8'h00, 2'b00, a);
      tick(1'b1, 1'b0, 1'b0, 8'h00, 2'b00, a);
      chk("rst_memWrite", 88'(memWrite), 88'(0));
      chk("rst_bank_full", 88'(bank_full), 88'(0));
      chk("rst_pix_ready", 88'(pix_ready), 88'(0));

      // region into bank 0, values 0..208
      clr_log();
      stream(209, 0);
      idle(2'b00);
      idle(2'b00);
      chk("b0_write_count", 88'(wr_cnt), 88'(19));
      chk("b0_first_addr", 88'(first_addr), 88'(0));
      chk("b0_last_addr", 88'(last_addr), 88'(18));
      chk("b0_row0_data", first_data, 88'h000102030405060708090A);
      chk("b0_full", 88'(bank_full), 88'(2'b01));

      // releasing a bank that is not full does nothing
      idle(2'b10);
      chk("bad_release_ignored", 88'(bank_full), 88'(2'b01));

      // region into bank 1, then stall on full bank 0
      clr_log();
      stream(209, 209);
      idle(2'b00);
      idle(2'b00);
      chk("b1_write_count", 88'(wr_cnt), 88'(19));
      chk("b1_first_addr", 88'(first_addr), 88'(32));
      chk("b1_last_addr", 88'(last_addr), 88'(50));
      chk("both_full", 88'(bank_full), 88'(2'b11));
      chk("stall_ready_low", 88'(pix_ready), 88'(0));
      idle(2'b01);
      chk("ready_after_release", 88'(pix_ready), 88'(1));
      clr_log();
      send(8'h40, 1'b1);
      stream(10, 8'h41);
      idle(2'b00);
      chk("resume_addr", 88'(first_addr), 88'(0));
      chk("resume_count", 88'(wr_cnt), 88'(1));

      // sof on pixel 5 of row 3
      stream(22 + 5, 8'h60);
      clr_log();
      send(8'hAB, 1'b1);
      stream(10, 8'hB0);
      idle(2'b00);
      chk("resync_pulse", 88'(err_seen), 88'(1));
      chk("resync_addr", 88'(first_addr), 88'(0));
      tmp = first_data;
      chk("resync_sof_pixel", 88'(tmp[87:80]), 88'(8'hAB));

      // finish bank 0, free bank 1, rst mid-row 7 of bank 1
      stream(18 * 11, 8'h10);
      idle(2'b10);
      stream(7 * 11 + 5, 8'h20);
      tick(1'b1, 1'b0, 1'b0, 8'h00, 2'b00, a);
      chk("midrst_memWrite", 88'(memWrite), 88'(0));
      chk("midrst_addr", 88'(sr_addressWrite), 88'(0));
      chk("midrst_data", writeData, 88'(0));
      chk("midrst_bank_full", 88'(bank_full), 88'(0));
      chk("midrst_err", 88'(err_resync), 88'(0));
      chk("midrst_ready", 88'(pix_ready), 88'(0));
      clr_log();
      stream(11, 8'hC0);
      idle(2'b00);
      chk("post_rst_addr", 88'(first_addr), 88'(0));
      chk("post_rst_count", 88'(wr_cnt), 88'(1));

      // randomized: 4 regions, 50% valid, random release delays
      start = m_writes;
      cyc = 0;
      while (m_writes - start < 4 * NROWS && cyc < 30000) begin
         rel = 2'b00;
         for (int b = 0; b < 2; b++)
            if (m_full[b] && $urandom_range(0, 15) == 0) rel[b] = 1'b1;
         tick(1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 499) == 0,
              8'($urandom), rel, a);
         cyc++;
      end
      chk("random_rows_done", 88'(m_writes - start >= 4 * NROWS), 88'(1));
      idle(2'b00);
      idle(2'b00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
